// File: rtl/key_counter_top.sv
// Debounced three-key up/down counter driving four LEDs and one hex digit of a
// common-anode seven-segment display.
module key_counter_top #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       CA,
  output logic       CB,
  output logic       CC,
  output logic       CD,
  output logic       CE,
  output logic       CF,
  output logic       CG,
  output logic       DP,
  output logic [7:0] AN
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Key channel index: 0 = E (clear), 1 = F (down), 2 = G (up).
  logic [2:0]      key_raw;
  logic [2:0]      s1_q, s2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      deb_prev_q;
  logic [2:0]      pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [3:0]      count_q, count_d;
  logic [6:0]      seg;

  assign key_raw = {G, F, E};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pulse_d = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= key_raw;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= pulse_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Clear dominates; simultaneous up and down cancel.
  always_comb begin
    count_d = count_q;
    if (pulse_q[0]) begin
      count_d = 4'd0;
    end else if (pulse_q[2] && !pulse_q[1]) begin
      count_d = count_q + 4'd1;
    end else if (pulse_q[1] && !pulse_q[2]) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Active-low segments, bit order {a,b,c,d,e,f,g}.
  always_comb begin
    seg = 7'b1111111;
    case (count_q)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

  assign {A, B, C, D}                  = count_q;
  assign {CA, CB, CC, CD, CE, CF, CG}  = seg;
  assign DP                            = 1'b1;
  assign AN                            = 8'b1111_1110;

endmodule

// File: tb/tb_key_counter_top.sv
// Randomized self-checking bench for key_counter_top against a run-length model
// of the key filtering and a table-driven display reference.
module tb_key_counter_top;

  localparam int unsigned N = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       E, F, G;
  logic       A, B, C, D;
  logic       CA, CB, CC, CD, CE, CF, CG;
  logic       DP;
  logic [7:0] AN;

  int n_cmp = 0;
  int n_mis = 0;

  key_counter_top #(.DEBOUNCE_CYCLES(N)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .E         (E),
    .F         (F),
    .G         (G),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .CA        (CA),
    .CB        (CB),
    .CC        (CC),
    .CD        (CD),
    .CE        (CE),
    .CF        (CF),
    .CG        (CG),
    .DP        (DP),
    .AN        (AN)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hex glyphs, active low {a..g}.
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
    glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
    glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
    glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
    glyph[15] = 7'b0111000;
  end

  // Reference model: raw samples seen two edges late, a key level is accepted after
  // N consecutive differing samples, and an accepted press acts two edges later.
  bit [2:0] m_hist [$];
  bit [2:0] m_act [$];
  int       m_run [3];
  bit [2:0] m_lvl;
  bit [3:0] m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    m_act = {3'b000, 3'b000};
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    m_lvl = '0;
    m_count = '0;
  endtask

  task automatic model_step(input bit [2:0] r);
    bit [2:0] seen;
    bit [2:0] press;
    bit [2:0] act;
    seen = (m_hist.size() == 2) ? m_hist[0] : 3'b000;
    m_hist.push_back(r);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
    press = '0;
    for (int k = 0; k < 3; k++) begin
      if (seen[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == int'(N)) begin
          m_lvl[k] = seen[k];
          m_run[k] = 0;
          press[k] = seen[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    act = m_act.pop_front();
    m_act.push_back(press);
    if (act[0]) m_count = 4'd0;
    else if (act[2] && !act[1]) m_count = m_count + 4'd1;
    else if (act[1] && !act[2]) m_count = m_count - 4'd1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_led"}, 32'({A, B, C, D}), 32'(m_count));
    check_eq({tag, "_seg"}, 32'({CA, CB, CC, CD, CE, CF, CG}), 32'(glyph[m_count]));
    check_eq({tag, "_dp"}, 32'(DP), 32'd1);
    check_eq({tag, "_an"}, 32'(AN), 32'hFE);
  endtask

  // Drive keys {G,F,E} for one clock, then compare at the falling edge.
  task automatic tick(input bit [2:0] r);
    {G, F, E} = r;
    @(posedge sys_clk);
    model_step(r);
    @(negedge sys_clk);
    check_outputs("cyc");
  endtask

  task automatic hold(input bit [2:0] r, input int n);
    for (int i = 0; i < n; i++) tick(r);
  endtask

  initial begin
    {G, F, E} = 3'b000;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("in_reset");
    #2 sys_rst_n = 1'b1;
    #1;
    check_outputs("post_reset");
    @(negedge sys_clk);

    // Clean G press: count changes exactly N+4 edges after first sample.
    hold(3'b100, N + 3);
    check_eq("g_latency_before", 32'({A, B, C, D}), 32'd0);
    tick(3'b100);
    check_eq("g_latency_at", 32'({A, B, C, D}), 32'd1);
    hold(3'b100, 12);
    check_eq("g_held", 32'({A, B, C, D}), 32'd1);
    check_eq("g_seg", 32'({CA, CB, CC, CD, CE, CF, CG}), 32'b1001111);
    hold(3'b000, 8);

    // Bounce train G/E/idle.
    for (int i = 0; i < 5; i++) begin
      tick(3'b100);
      tick(3'b001);
      tick(3'b000);
    end
    hold(3'b000, 8);
    check_eq("bounce_ge", 32'({A, B, C, D}), 32'd1);

    hold(3'b010, 10);
    hold(3'b000, 8);
    check_eq("f_dec", 32'({A, B, C, D}), 32'd0);
    hold(3'b010, 10);
    hold(3'b000, 8);
    check_eq("f_wrap", 32'({A, B, C, D}), 32'd15);
    check_eq("f_wrap_seg", 32'({CA, CB, CC, CD, CE, CF, CG}), 32'b0111000);

    for (int i = 0; i < 4; i++) begin
      tick(3'b101);
      tick(3'b000);
    end
    hold(3'b000, 8);
    check_eq("bounce_eg", 32'({A, B, C, D}), 32'd15);
    hold(3'b001, 10);
    hold(3'b000, 8);
    check_eq("e_clear", 32'({A, B, C, D}), 32'd0);

    for (int i = 0; i < 16; i++) begin
      hold(3'b100, 6);
      hold(3'b000, 6);
    end
    check_eq("g_x16", 32'({A, B, C, D}), 32'd0);
    hold(3'b100, 6);
    hold(3'b000, 8);
    hold(3'b110, 10);
    hold(3'b000, 8);
    check_eq("fg_same", 32'({A, B, C, D}), 32'd1);

    // Reset during a partial debounce must discard the partial count.
    hold(3'b100, 3);
    #1 sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    hold(3'b100, 1);
    hold(3'b000, 10);
    check_eq("partial_discard", 32'({A, B, C, D}), 32'd0);

    // Random key patterns with mixed short bounces and long holds.
    for (int s = 0; s < 120; s++) begin
      hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 12)));
    end
    hold(3'b000, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
